// File: rtl/pc_sequencer.sv
// Program-counter unit: holds the PC and picks the next one from a sequential step, a redirect,
// or a return-address stack, under a boot/run/halt FSM.
module pc_sequencer #(
    parameter int unsigned              ADDR_WIDTH   = 32,
    parameter int unsigned              STEP         = 4,
    parameter logic [ADDR_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter int unsigned              RAS_DEPTH    = 4,
    parameter int unsigned              ALIGN_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    input  logic                  call,
    input  logic                  ret,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_next,
    output logic                  pc_valid,
    output logic                  misaligned,
    output logic                  ras_empty,
    output logic                  ras_full,
    output logic                  ras_underflow,
    output logic [1:0]            state
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDR_WIDTH-1:0] STEP_W     = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [CNT_W-1:0]      FULL_CNT   = CNT_W'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT    = 2'b00,
        ST_RUN     = 2'b01,
        ST_HALTED  = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_seq, ras_top;
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]      ras_ptr;
    logic [CNT_W-1:0]      ras_cnt;
    logic                  misaligned_q, misaligned_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop;

    assign pc_seq  = pc_q + STEP_W;
    // ras_ptr addresses the next free slot, so the top lives one below it (wrapping).
    assign ras_top = ras_mem[ras_ptr - PTR_W'(1)];

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        push         = 1'b0;
        pop          = 1'b0;
        misaligned_d = 1'b0;
        underflow_d  = underflow_q;
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALTED;
                end else if (!stall) begin
                    if (ret) begin
                        if (ras_cnt != '0) begin
                            pc_d = ras_top;
                            pop  = 1'b1;
                        end else begin
                            pc_d        = pc_seq;
                            underflow_d = 1'b1;
                        end
                    end else if (redirect_valid) begin
                        if ((redirect_target & ALIGN_MASK) != '0) begin
                            misaligned_d = 1'b1;
                        end else begin
                            pc_d = redirect_target;
                            push = call;
                        end
                    end else begin
                        pc_d = pc_seq;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
            underflow_q  <= 1'b0;
            ras_ptr      <= '0;
            ras_cnt      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            underflow_q  <= underflow_d;
            if (push) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_cnt != FULL_CNT) ras_cnt <= ras_cnt + CNT_W'(1);
            end else if (pop) begin
                ras_ptr <= ras_ptr - PTR_W'(1);
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
        end
    end

    // NOTE: the stack storage is not reset; ras_cnt alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) ras_mem[ras_ptr] <= pc_seq;
    end

    assign pc            = pc_q;
    assign pc_next       = pc_d;
    assign pc_valid      = (state_q == ST_RUN);
    assign misaligned    = misaligned_q;
    assign ras_empty     = (ras_cnt == '0);
    assign ras_full      = (ras_cnt == FULL_CNT);
    assign ras_underflow = underflow_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: a behavioural model pushes expected post-edge state
// into a scoreboard queue that is popped and compared after each clock edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, halt = 1'b0, redirect_valid = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc, pc_next;
    logic        pc_valid, misaligned, ras_empty, ras_full, ras_underflow;
    logic [1:0]  state;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .call(call), .ret(ret), .pc(pc), .pc_next(pc_next), .pc_valid(pc_valid),
        .misaligned(misaligned), .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_underflow(ras_underflow), .state(state)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  st;
        logic        valid, mis, empty, full, und;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_ras[$];
    logic [31:0] m_pc;
    logic [1:0]  m_state;
    logic        m_und;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_state = 2'b00; m_und = 1'b0;
        m_ras.delete();
        sb.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_pc", pc, 32'h0);
        check("rst_state", state, 2'b00);
        check("rst_valid", pc_valid, 1'b0);
        check("rst_mis", misaligned, 1'b0);
        check("rst_empty", ras_empty, 1'b1);
        check("rst_full", ras_full, 1'b0);
        check("rst_und", ras_underflow, 1'b0);
    endtask

    // Release reset just after a rising edge so the next edge is the first one seen in BOOT.
    task automatic release_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic s, input logic h, input logic rv, input logic [31:0] tgt,
                         input logic c, input logic r);
        exp_t e;
        logic mis = 1'b0;
        @(negedge clk);
        stall = s; halt = h; redirect_valid = rv; redirect_target = tgt; call = c; ret = r;
        #1;
        case (m_state)
            2'b00: m_state = 2'b01;
            2'b01: begin
                if (h) m_state = 2'b10;
                else if (!s) begin
                    if (r) begin
                        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
                        else begin m_pc = m_pc + 32'd4; m_und = 1'b1; end
                    end else if (rv) begin
                        if (tgt[1:0] != 2'b00) mis = 1'b1;
                        else begin
                            if (c) begin
                                if (m_ras.size() == 4) void'(m_ras.pop_front());
                                m_ras.push_back(m_pc + 32'd4);
                            end
                            m_pc = tgt;
                        end
                    end else m_pc = m_pc + 32'd4;
                end
            end
            default: ;
        endcase
        check("pc_next", pc_next, m_pc);
        e.pc = m_pc; e.st = m_state; e.valid = (m_state == 2'b01); e.mis = mis;
        e.empty = (m_ras.size() == 0); e.full = (m_ras.size() == 4); e.und = m_und;
        sb.push_back(e);
        @(posedge clk); #1;
        if (sb.size() == 0) begin
            check("sb_underrun", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("state", state, e.st);
            check("pc_valid", pc_valid, e.valid);
            check("misaligned", misaligned, e.mis);
            check("ras_empty", ras_empty, e.empty);
            check("ras_full", ras_full, e.full);
            check("ras_underflow", ras_underflow, e.und);
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h54; ret_exp[1] = 32'h44; ret_exp[2] = 32'h34; ret_exp[3] = 32'h24;
        model_reset();
        #3;
        check_reset_outputs();
        release_reset();

        // T1: one BOOT cycle then sequential fetch 0,4,8,C
        idle();
        check("t1_boot_pc", pc, 32'h0);
        repeat (3) idle();
        check("t1_pc", pc, 32'hC);

        // T2: wrap at top of address space
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        idle();
        check("t2_wrap", pc, 32'h0);

        // T3: call then return
        cycle(1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        check("t3_call", pc, 32'h200);
        idle();
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t3_ret", pc, 32'h104);
        check("t3_empty", ras_empty, 1'b1);

        // T4: overfill the stack, drain it, then underflow
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'(i * 16), 1'b0, 1'b0);
            cycle(1'b0, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0);
        end
        check("t4_full", ras_full, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check("t4_ret", pc, ret_exp[i]);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        check("t4_uf_pc", pc, 32'h28);
        check("t4_uf", ras_underflow, 1'b1);

        // T5: misaligned redirect is rejected; stall blocks a redirect
        cycle(1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h202, 1'b1, 1'b0);
        check("t5_hold", pc, 32'h300);
        check("t5_mis", misaligned, 1'b1);
        idle();
        check("t5_mis_clr", misaligned, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 1'b0);
        check("t5_stall", pc, 32'h304);

        // Mixed traffic with aligned/misaligned targets and stalls
        for (int i = 0; i < 40; i++) begin
            cycle(($urandom_range(0, 4) == 0), 1'b0, $urandom_range(0, 1) == 1,
                  {$urandom_range(0, 255), 4'h0, 2'($urandom_range(0, 3) == 0 ? 2 : 0)},
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 3) == 0));
        end

        // T6: halt wins over stall, state freezes, async reset mid-run
        cycle(1'b0, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        check("t6_halted", state, 2'b10);
        check("t6_valid", pc_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0);
        idle();
        check("t6_frozen", pc, 32'h500);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        release_reset();
        repeat (3) idle();
        check("t6_restart", pc, 32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
